ysyx_23060077_riscv_ifu: RTL

Instruction fetch unit directly upstream of the decode stage. It owns the PC, issues one outstanding word fetch to instruction memory, and hands the returned instruction and its PC to decode over a valid/ready handshake. A redirect from execute (jump, branch, trap) overrides the PC and discards any stale or in-flight fetch.

---
 rtl/ysyx_23060077_riscv_ifu_pkg.sv | 24 ++
 rtl/ysyx_23060077_riscv_ifu_pc.sv | 46 ++++
 rtl/ysyx_23060077_riscv_ifu.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ysyx_23060077_riscv_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC,
// FSM encoding and PC arithmetic helpers.
package ysyx_23060077_riscv_ifu_pkg;

    localparam int          IFU_DATA_WIDTH = 32;
    localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
    localparam int          IFU_PC_INC     = 4;

    // Fetch progress: REQ drives a request, WAIT holds one outstanding
    // fetch, HOLD presents an instruction to decode.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

    // Snapshot of the FSM-side registers, handy for binding checkers.
    typedef struct packed {
        ifu_state_e state;
        logic       drop;
        logic       id_valid;
    } ifu_dbg_t;

endpackage

// File: rtl/ysyx_23060077_riscv_ifu_pc.sv
// Program counter: reset load, sequential +4 advance and redirect mux.
// The two low bits are forced to zero on every load path so the PC is
// always word aligned.
module ysyx_23060077_riscv_ifu_pc
    import ysyx_23060077_riscv_ifu_pkg::*;
#(
    parameter int                    DATA_WIDTH = IFU_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  inc_en,
    output logic [DATA_WIDTH-1:0] pc
);

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(IFU_PC_INC);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    // Next PC: redirect wins over the sequential advance; the add wraps
    // naturally modulo 2^DATA_WIDTH.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ALIGN_MASK;
        end else if (inc_en) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC register, loaded with the aligned reset vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC & ALIGN_MASK;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ysyx_23060077_riscv_ifu.sv
// Instruction fetch unit. Owns the PC, keeps at most one word fetch in
// flight and hands the returned instruction plus its PC to decode.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. imem_req_valid stays high in REQ until accepted and its
// address may change if a redirect arrives before acceptance. id_valid
// stays high with id_inst/id_pc stable until id_ready, unless a redirect
// withdraws the instruction (it is then not consumed, even if id_ready
// was high in that cycle).
module ysyx_23060077_riscv_ifu
    import ysyx_23060077_riscv_ifu_pkg::*;
#(
    parameter int                    DATA_WIDTH = IFU_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_inst,
    output logic [DATA_WIDTH-1:0] id_pc
);

    ifu_state_e            state_q, state_d;
    logic                  drop_q, drop_d;
    logic                  id_valid_q, id_valid_d;
    logic [DATA_WIDTH-1:0] id_inst_q, id_inst_d;
    logic [DATA_WIDTH-1:0] id_pc_q, id_pc_d;
    logic                  pc_inc;
    logic [DATA_WIDTH-1:0] pc;
    logic                  req_fire;
    ifu_dbg_t              dbg;

    ysyx_23060077_riscv_ifu_pc #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inc_en         (pc_inc),
        .pc             (pc)
    );

    // Request accepted this cycle (request valid is implied by REQ).
    assign req_fire = (state_q == ST_REQ) && imem_req_ready;

    // Next-state and buffer update; a redirect overrides every other event.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        pc_inc     = 1'b0;
        if (redirect_valid) begin
            id_valid_d = 1'b0;
            case (state_q)
                ST_REQ: begin
                    // An accepted old-address fetch must be swallowed.
                    if (req_fire) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_REQ;
                end
                default: begin
                    state_d = ST_REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            id_inst_d  = imem_rsp_data;
                            id_pc_d    = pc;
                            id_valid_d = 1'b1;
                            pc_inc     = 1'b1;
                            state_d    = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (id_valid_q && id_ready) begin
                        id_valid_d = 1'b0;
                        state_d    = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end
    end

    // FSM and decode buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_REQ;
            drop_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
        end
    end

    // No request is presented while reset is held, so an asserted reset
    // withdraws the request immediately rather than exposing REQ.
    assign imem_req_valid = (state_q == ST_REQ) && rst_n;
    assign imem_req_addr  = pc;
    assign id_valid       = id_valid_q;
    assign id_inst        = id_inst_q;
    assign id_pc          = id_pc_q;

    // Debug view of the FSM registers for hierarchical probing.
    assign dbg = '{state: state_q, drop: drop_q, id_valid: id_valid_q};

endmodule
